// File: rtl/ram_bank.sv
// ram_bank: single-clock word RAM with byte-enable request port, zero-fill clear engine
// and an optional registered debug peek port enabled by the RAM_BANK_PEEK_EN macro.
module ram_bank #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 32,
  parameter int RDW_MODE = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_W-1:0]     i_req_addr,
  input  logic [DATA_W-1:0]     i_req_wdata,
  input  logic [DATA_W/8-1:0]   i_req_be,
  output logic                  o_rsp_valid,
  output logic [DATA_W-1:0]     o_rsp_rdata,
  output logic                  o_rsp_err,
  input  logic                  i_clear_start,
  output logic                  o_clear_busy,
  input  logic [ADDR_W-1:0]     i_peek_addr,
  output logic [DATA_W-1:0]     o_peek_data
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_peek_data;

  logic                w_accept;
  logic                w_in_range;
  logic                w_wr_en;
  logic [IDX_W-1:0]    w_req_idx;
  logic [DATA_W-1:0]   w_old;
  logic [DATA_W-1:0]   w_merged;
  logic [DATA_W-1:0]   w_rsp_data;

  function automatic logic [DATA_W-1:0] f_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign w_accept   = i_req_valid && (r_state == S_IDLE);
  assign w_in_range = (i_req_addr < DEPTH_A);
  assign w_req_idx  = i_req_addr[IDX_W-1:0];
  assign w_wr_en    = w_accept && i_req_we && w_in_range;
  assign w_old      = r_mem[w_req_idx];
  assign w_merged   = f_merge(w_old, i_req_wdata, i_req_be);
  assign w_rsp_data = (i_req_we && (RDW_MODE == 0)) ? w_merged : w_old;

  // Clear engine sequencing: CLEAR walks every index once, IDLE waits for clear_start.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_CLEAR: begin
        if (r_idx == LAST_IDX) w_next_state = S_IDLE;
        else                   w_next_state = S_CLEAR;
      end
      S_IDLE: begin
        if (i_clear_start) w_next_state = S_CLEAR;
        else               w_next_state = S_IDLE;
      end
      default: w_next_state = S_CLEAR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= ((r_state == S_CLEAR) && (r_idx != LAST_IDX)) ? r_idx + IDX_W'(1) : '0;
    end
  end

  // Array has no reset; the clear engine owns zero-filling it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_idx] <= '0;
      end else if (w_wr_en) begin
        r_mem[w_req_idx] <= w_merged;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        r_rsp_rdata <= w_in_range ? w_rsp_data : '0;
        r_rsp_err   <= !w_in_range;
      end
    end
  end

`ifdef RAM_BANK_PEEK_EN
  logic w_peek_in_range;
  assign w_peek_in_range = (i_peek_addr < DEPTH_A);

  // Non-blocking read sees the array before any same-edge write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_peek_data <= '0;
    end else if (w_peek_in_range) begin
      r_peek_data <= r_mem[i_peek_addr[IDX_W-1:0]];
    end else begin
      r_peek_data <= '0;
    end
  end
`else
  logic w_unused_peek;
  assign w_unused_peek = ^i_peek_addr;
  assign r_peek_data   = '0;
`endif

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_clear_busy = (r_state == S_CLEAR);
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_rdata  = r_rsp_rdata;
  assign o_rsp_err    = r_rsp_err;
  assign o_peek_data  = r_peek_data;

endmodule

// File: tb/tb_ram_bank.sv
// Testbench for ram_bank: table-driven request vectors on a write-first and a read-first
// instance, plus hand-written clear/reset sequences.
module tb_ram_bank;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AW = 32;
`ifdef RAM_BANK_PEEK_EN
  localparam bit PEEK_ON = 1'b1;
`else
  localparam bit PEEK_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, req_valid, req_we, clear_start;
  logic [AW-1:0] req_addr, peek_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          wf_ready, wf_rvalid, wf_err, wf_busy;
  logic [DW-1:0] wf_rdata, wf_peek;
  logic          rf_ready, rf_rvalid, rf_err, rf_busy;
  logic [DW-1:0] rf_rdata, rf_peek;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_bank #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RDW_MODE(0)) u_wf (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(wf_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rsp_valid(wf_rvalid), .o_rsp_rdata(wf_rdata), .o_rsp_err(wf_err),
    .i_clear_start(clear_start), .o_clear_busy(wf_busy),
    .i_peek_addr(peek_addr), .o_peek_data(wf_peek));

  ram_bank #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RDW_MODE(1)) u_rf (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(rf_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rsp_valid(rf_rvalid), .o_rsp_rdata(rf_rdata), .o_rsp_err(rf_err),
    .i_clear_start(clear_start), .o_clear_busy(rf_busy),
    .i_peek_addr(peek_addr), .o_peek_data(rf_peek));

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
    logic [AW-1:0] paddr;
    logic [DW-1:0] exp_wf;
    logic [DW-1:0] exp_rf;
    logic          exp_err;
    logic [DW-1:0] exp_peek;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [3:0] be, input logic clr);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    clear_start = clr;
    step();
    req_valid = 1'b0; clear_start = 1'b0;
  endtask

  // Counts cycles with clear_busy high; pokes clear_start mid-way, which must be ignored.
  task automatic count_busy(input string name, input bit poke);
    int cnt;
    cnt = 0;
    while (wf_busy && cnt < 4 * DEPTH) begin
      cnt++;
      clear_start = poke && (cnt == 3);
      chk({name, "_ready_low"}, {31'd0, wf_ready}, 32'd0);
      step();
    end
    clear_start = 1'b0;
    chk({name, "_busy_cycles"}, cnt, DEPTH);
    chk({name, "_ready_after"}, {31'd0, wf_ready}, 32'd1);
    chk({name, "_rf_busy"}, {31'd0, rf_busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = 4'h0; clear_start = 1'b0; peek_addr = 32'd3;

    //            we    addr          wdata          be       paddr   exp_wf         exp_rf         err   peek(old word)
    vecs[0]  = '{1'b0, 32'd5,        32'h0,         4'hF,    32'd3,  32'h0,         32'h0,         1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'd3,        32'hDEADBEEF,  4'hF,    32'd3,  32'hDEADBEEF,  32'h0,         1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'd3,        32'h00001122,  4'b0011, 32'd3,  32'hDEAD1122,  32'hDEADBEEF,  1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 32'd3,        32'h0,         4'h0,    32'd3,  32'hDEAD1122,  32'hDEAD1122,  1'b0, 32'hDEAD1122};
    vecs[4]  = '{1'b1, 32'd7,        32'h11111111,  4'hF,    32'd3,  32'h11111111,  32'h0,         1'b0, 32'hDEAD1122};
    vecs[5]  = '{1'b1, 32'd7,        32'hA5A5A5A5,  4'hF,    32'd7,  32'hA5A5A5A5,  32'h11111111,  1'b0, 32'h11111111};
    vecs[6]  = '{1'b1, 32'd7,        32'hFFFFFFFF,  4'h0,    32'd7,  32'hA5A5A5A5,  32'hA5A5A5A5,  1'b0, 32'hA5A5A5A5};
    vecs[7]  = '{1'b1, 32'd7,        32'h00CC0000,  4'b0100, 32'd7,  32'hA5CCA5A5,  32'hA5A5A5A5,  1'b0, 32'hA5A5A5A5};
    vecs[8]  = '{1'b1, 32'd0,        32'h12345678,  4'hF,    32'd7,  32'h12345678,  32'h0,         1'b0, 32'hA5CCA5A5};
    vecs[9]  = '{1'b1, 32'd15,       32'h87654321,  4'hF,    32'd15, 32'h87654321,  32'h0,         1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'd16,       32'h0,         4'h0,    32'd16, 32'h0,         32'h0,         1'b1, 32'h0};
    vecs[11] = '{1'b1, 32'd16,       32'hFFFFFFFF,  4'hF,    32'd15, 32'h0,         32'h0,         1'b1, 32'h87654321};
    vecs[12] = '{1'b0, 32'd0,        32'h0,         4'h0,    32'd0,  32'h12345678,  32'h12345678,  1'b0, 32'h12345678};
    vecs[13] = '{1'b0, 32'd15,       32'h0,         4'h0,    32'd15, 32'h87654321,  32'h87654321,  1'b0, 32'h87654321};
    vecs[14] = '{1'b1, 32'hFFFFFFF0, 32'h55555555,  4'hF,    32'd0,  32'h0,         32'h0,         1'b1, 32'h12345678};
    vecs[15] = '{1'b0, 32'd7,        32'h0,         4'h0,    32'd7,  32'hA5CCA5A5,  32'hA5CCA5A5,  1'b0, 32'hA5CCA5A5};

    step(); step();
    chk("rst_rsp_valid", {31'd0, wf_rvalid}, 32'd0);
    chk("rst_rsp_rdata", wf_rdata, 32'd0);
    chk("rst_rsp_err",   {31'd0, wf_err}, 32'd0);
    chk("rst_busy",      {31'd0, wf_busy}, 32'd1);
    chk("rst_ready",     {31'd0, wf_ready}, 32'd0);
    chk("rst_peek",      wf_peek, 32'd0);
    rst = 1'b0;
    count_busy("init", 1'b0);

    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_we = vecs[i].we; req_addr = vecs[i].addr;
      req_wdata = vecs[i].wdata; req_be = vecs[i].be; peek_addr = vecs[i].paddr;
      step();
      chk($sformatf("v%0d_valid", i), {31'd0, wf_rvalid & rf_rvalid}, 32'd1);
      chk($sformatf("v%0d_wf_rdata", i), wf_rdata, vecs[i].exp_wf);
      chk($sformatf("v%0d_rf_rdata", i), rf_rdata, vecs[i].exp_rf);
      chk($sformatf("v%0d_err", i), {30'd0, wf_err, rf_err}, {30'd0, vecs[i].exp_err, vecs[i].exp_err});
      chk($sformatf("v%0d_peek", i), wf_peek, PEEK_ON ? vecs[i].exp_peek : 32'h0);
    end
    req_valid = 1'b0;
    step();
    chk("idle_valid", {31'd0, wf_rvalid}, 32'd0);
    chk("idle_hold_rdata", wf_rdata, 32'hA5CCA5A5);
    chk("idle_hold_err", {31'd0, wf_err}, 32'd0);

    // Clear with a same-cycle read: the read completes with the old value.
    do_req(1'b1, 32'd1, 32'h01010101, 4'hF, 1'b0);
    do_req(1'b1, 32'd2, 32'h02020202, 4'hF, 1'b0);
    do_req(1'b0, 32'd2, 32'h0, 4'h0, 1'b1);
    chk("clr_read_valid", {31'd0, wf_rvalid}, 32'd1);
    chk("clr_read_old", wf_rdata, 32'h02020202);
    chk("clr_busy_start", {31'd0, wf_busy}, 32'd1);
    count_busy("clear", 1'b1);
    for (int a = 0; a < 4; a++) begin
      do_req(1'b0, a, 32'h0, 4'h0, 1'b0);
      chk($sformatf("cleared_%0d", a), wf_rdata, 32'h0);
    end
    do_req(1'b0, 32'd15, 32'h0, 4'h0, 1'b0);
    chk("cleared_15", rf_rdata, 32'h0);

    // Second clear interrupted by reset together with a pending request.
    do_req(1'b1, 32'd3, 32'h33333333, 4'hF, 1'b0);
    clear_start = 1'b1; step(); clear_start = 1'b0;
    for (int k = 0; k < DEPTH / 2; k++) step();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd3;
    step();
    rst = 1'b0; req_valid = 1'b0;
    chk("rst_mid_valid", {31'd0, wf_rvalid}, 32'd0);
    chk("rst_mid_busy", {31'd0, wf_busy}, 32'd1);
    count_busy("restart", 1'b0);
    do_req(1'b0, 32'd3, 32'h0, 4'h0, 1'b0);
    chk("restart_cleared_3", wf_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_bank.md
# ram_bank

Parametrised single-clock data memory for a compute node: one request/response port for the core's load/store unit plus an independent read-only peek port for debug/readout. Generalises the fixed 32-bit × 1024-word node RAM with configurable width/depth, byte-enable writes, selectable read-during-write behaviour, address range checking and a hardware clear engine that zero-fills the array after reset or on command.

## Interface
- DATA_W, 32, data word width in bits; multiple of 8
- DEPTH, 1024, number of words; any value ≥ 2
- ADDR_W, 32, request/peek address width; addresses ≥ DEPTH are out of range
- RDW_MODE, 0, read-during-write on the request port: 0 = write-first (new data), 1 = read-first (old data)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid && ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i]
- rsp_valid  out  1  one-cycle pulse, one per accepted request
- rsp_rdata  out  DATA_W  word at req_addr after/before write per RDW_MODE; 0 on error
- rsp_err  out  1  accepted request had out-of-range address
- clear_start  in  1  pulse: start zero-fill
- clear_busy  out  1  clear engine active
- peek_addr  in  ADDR_W  peek word address
- peek_data  out  DATA_W  registered peek result

## Operation
- FSM states: CLEAR, IDLE.
- rst → CLEAR, clear index = 0. CLEAR writes 0 to word[index] each cycle, index increments; after writing index DEPTH-1 → IDLE. Full clear takes exactly DEPTH cycles.
- IDLE + clear_start → CLEAR with index 0. clear_start while in CLEAR ignored (no restart).
- req_ready = (state == IDLE). No requests accepted during CLEAR.
- Accepted write, in range: for each i with req_be[i]=1, byte i ← req_wdata byte i; other bytes unchanged. req_be = 0 is a legal no-op write that still responds.
- Accepted read, in range: rsp_rdata = stored word.
- Accepted write in write-first mode returns the merged new word; read-first returns the pre-write word.
- Out of range (req_addr ≥ DEPTH): no array change, rsp_rdata = 0, rsp_err = 1.
- Same-cycle clear_start and accepted request in IDLE: request executes and responds normally; CLEAR begins the following cycle.
- Peek port: every cycle peek_data ← word[peek_addr] (0 if out of range); reads the array before any same-cycle write (old data), including clear writes.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, clear_busy 1, peek_data 0.
- Request → response latency 1 cycle: request accepted at edge N, rsp_valid/rsp_rdata/rsp_err valid in cycle after N, for one cycle only. Full throughput: one request per cycle in IDLE.
- rsp_rdata/rsp_err hold last value when rsp_valid = 0; rsp_err clears on next in-range response.
- clear_busy = (state == CLEAR); first cycle after rst deassertion clear_busy = 1, req_ready = 0; req_ready rises DEPTH cycles later.
- rst asserted mid-clear or mid-transaction: pending response dropped (rsp_valid 0 next cycle), clear restarts from index 0.
- Peek latency 1 cycle, no handshake.

## Configuration
- RAM_BANK_PEEK_EN defined: peek port functional as above (second read port on the array).
- Undefined: no second read port inferred; peek_data held at 0 permanently; peek_addr ignored.

## Test plan
- Reset then poll: clear_busy = 1 for exactly DEPTH cycles, req_ready rises on cycle DEPTH; reading addr 5 returns 0, rsp_err 0.
- Write 0xDEADBEEF to addr 3 (be=4'hF), then write 0x00001122 with be=4'b0011, then read addr 3 → 0xDEAD1122 one cycle after acceptance.
- Write 0xA5A5A5A5 to addr 7 after addr 7 holds 0x11111111: RDW_MODE=0 → rsp_rdata 0xA5A5A5A5; RDW_MODE=1 → 0x11111111.
- Read and write to addr DEPTH → rsp_err 1, rsp_rdata 0, addr 0 and DEPTH-1 unchanged.
- Fill addr 0..3 with nonzero, pulse clear_start together with a read of addr 2 → read returns old value, then req_ready 0 for DEPTH cycles, afterwards addr 0..3 read 0; rst asserted halfway through a second clear → clear restarts, clear_busy lasts full DEPTH cycles.
- With RAM_BANK_PEEK_EN: peek addr 3 while writing addr 3 → old data that cycle, new data next cycle; without macro peek_data stays 0.
